// File: rtl/regfile_wb_arbiter_pkg.sv
// regfile_wb_arbiter_pkg: shared widths and constants for the write-back arbiter
//   DATA_W_DEF : default write-back data width
//   ADDR_W_DEF : default register address width
//   STARVE_W   : starvation counter width
//   X0         : hard-wired zero register address (writes to it are dropped)
package regfile_wb_arbiter_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int STARVE_W   = 8;
    localparam int X0         = 0;
endpackage

// File: rtl/regfile_wb_arbiter_starve_ctr.sv
// wb_starve_ctr: counts consecutive stalled cycles of source 1 and raises prio1 at the limit
//   clk, rst     : clock, asynchronous active-high reset
//   req1_valid   : source 1 is requesting
//   req1_ready   : source 1 is granted this cycle
//   prio1        : registered flag giving source 1 priority over source 0
module wb_starve_ctr
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic req1_valid,
    input  logic req1_ready,
    output logic prio1
);
    localparam logic [STARVE_W-1:0] LIM = STARVE_W'(STARVE_LIMIT);
    logic [STARVE_W-1:0] cnt, cnt_nxt;
    always_comb cnt_nxt = (!req1_valid || req1_ready) ? '0 : (cnt == LIM) ? cnt : cnt + 1'b1;
    // prio1 is registered from the next count so it equals (cnt == LIM) every cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            prio1 <= 1'b0;
        end else begin
            cnt   <= cnt_nxt;
            prio1 <= (cnt_nxt == LIM);
        end
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: arbitrates two write-back sources onto one register-file write port
//   clk, rst                          : clock, asynchronous active-high reset
//   req0_valid/rd/data, req0_ready    : source 0 (ALU/immediate) handshake
//   req1_valid/rd/data, req1_ready    : source 1 (load/multi-cycle) handshake
//   RegWrite, rd, write_data          : registered write triple to the register file
//   q_rs1/q_rs2, q_hit1/q_hit2        : combinational pending-write hazard query
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int DATA_W       = DATA_W_DEF,
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_rd,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_rd,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] rd,
    output logic [DATA_W-1:0] write_data,
    input  logic [ADDR_W-1:0] q_rs1,
    input  logic [ADDR_W-1:0] q_rs2,
    output logic              q_hit1,
    output logic              q_hit2
);
    localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(X0);
    logic              prio1;
    logic [ADDR_W-1:0] sel_rd;
    logic [DATA_W-1:0] sel_data;
    logic              wr;

    wb_starve_ctr #(.STARVE_LIMIT(STARVE_LIMIT)) u_starve (
        .clk        (clk),
        .rst        (rst),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .prio1      (prio1)
    );

    assign req0_ready = req0_valid && (!prio1 || !req1_valid);
    assign req1_ready = req1_valid && (prio1 || !req0_valid);
    assign sel_rd     = req1_ready ? req1_rd : req0_rd;
    assign sel_data   = req1_ready ? req1_data : req0_data;
    // Transfers to x0 complete the handshake but never reach the register file.
    assign wr         = (req0_ready || req1_ready) && (sel_rd != ZERO);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            RegWrite   <= 1'b0;
            rd         <= '0;
            write_data <= '0;
        end else begin
            RegWrite <= wr;
            if (wr) begin
                rd         <= sel_rd;
                write_data <= sel_data;
            end
        end
    end

    // Pending = requested by either source or sitting in the output stage this cycle.
    function automatic logic pending(input logic [ADDR_W-1:0] q);
        return (q != ZERO) && ((req0_valid && req0_rd == q) || (req1_valid && req1_rd == q) || (RegWrite && rd == q));
    endfunction

    assign q_hit1 = pending(q_rs1);
    assign q_hit2 = pending(q_rs2);
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic [4:0]  req0_rd = '0, req1_rd = '0, q_rs1 = '0, q_rs2 = '0;
    logic [31:0] req0_data = '0, req1_data = '0;
    logic        req0_ready, req1_ready, RegWrite, q_hit1, q_hit2;
    logic [4:0]  rd;
    logic [31:0] write_data;
    int vectors = 0;
    int miscompares = 0;

    regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_rd(req0_rd), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_rd(req1_rd), .req1_data(req1_data), .req1_ready(req1_ready),
        .RegWrite(RegWrite), .rd(rd), .write_data(write_data),
        .q_rs1(q_rs1), .q_rs2(q_rs2), .q_hit1(q_hit1), .q_hit2(q_hit2)
    );

    always #5 clk = ~clk;

    // Source protocol: a stalled request must stay valid and stable until accepted.
    logic        pend0 = 1'b0, pend1 = 1'b0;
    logic [4:0]  h0_rd, h1_rd;
    logic [31:0] h0_data, h1_data;
    always @(posedge clk) begin
        if (!rst) begin
            assert (!pend0 || (req0_valid && req0_rd == h0_rd && req0_data == h0_data)) else $error("source 0 request withdrawn or changed while stalled");
            assert (!pend1 || (req1_valid && req1_rd == h1_rd && req1_data == h1_data)) else $error("source 1 request withdrawn or changed while stalled");
        end
        pend0   <= !rst && req0_valid && !req0_ready;
        pend1   <= !rst && req1_valid && !req1_ready;
        h0_rd   <= req0_rd;
        h0_data <= req0_data;
        h1_rd   <= req1_rd;
        h1_data <= req1_data;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        repeat (2) tick();
        rst = 1'b0;
        #1;
        vectors++; if (RegWrite !== 1'b0) begin miscompares++; $display("FAIL reset_we got %b want 0", RegWrite); end
        vectors++; if (rd !== 5'd0) begin miscompares++; $display("FAIL reset_rd got %0d want 0", rd); end
        vectors++; if (write_data !== 32'h0) begin miscompares++; $display("FAIL reset_wd got %h want 0", write_data); end
        req0_valid = 1'b1; req0_rd = 5'd5; req0_data = 32'hA5A5_A5A5;
        tick();
        vectors++; if (RegWrite !== 1'b1) begin miscompares++; $display("FAIL pre_reset_we got %b want 1", RegWrite); end
        #1 rst = 1'b1;
        #1;
        vectors++; if (RegWrite !== 1'b0) begin miscompares++; $display("FAIL async_reset_we got %b want 0", RegWrite); end
        vectors++; if (rd !== 5'd0) begin miscompares++; $display("FAIL async_reset_rd got %0d want 0", rd); end
        vectors++; if (write_data !== 32'h0) begin miscompares++; $display("FAIL async_reset_wd got %h want 0", write_data); end
        rst = 1'b0;
        #1;
        vectors++; if (req0_ready !== 1'b1) begin miscompares++; $display("FAIL post_reset_ready0 got %b want 1", req0_ready); end
        req0_valid = 1'b0;
        tick();
    endtask

    task automatic test_single_write;
        req0_valid = 1'b1; req0_rd = 5'd5; req0_data = 32'hDEAD_BEEF;
        #1;
        vectors++; if (req0_ready !== 1'b1) begin miscompares++; $display("FAIL single_ready0 got %b want 1", req0_ready); end
        tick();
        req0_valid = 1'b0;
        vectors++; if (RegWrite !== 1'b1) begin miscompares++; $display("FAIL single_we got %b want 1", RegWrite); end
        vectors++; if (rd !== 5'd5) begin miscompares++; $display("FAIL single_rd got %0d want 5", rd); end
        vectors++; if (write_data !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL single_wd got %h want deadbeef", write_data); end
        tick();
        vectors++; if (RegWrite !== 1'b0) begin miscompares++; $display("FAIL single_we_off got %b want 0", RegWrite); end
        vectors++; if (rd !== 5'd5) begin miscompares++; $display("FAIL single_rd_hold got %0d want 5", rd); end
    endtask

    task automatic test_contention;
        req0_valid = 1'b1; req0_rd = 5'd3; req0_data = 32'h0000_0333;
        req1_valid = 1'b1; req1_rd = 5'd4; req1_data = 32'h0000_0444;
        #1;
        vectors++; if (req0_ready !== 1'b1) begin miscompares++; $display("FAIL cont_ready0 got %b want 1", req0_ready); end
        vectors++; if (req1_ready !== 1'b0) begin miscompares++; $display("FAIL cont_ready1 got %b want 0", req1_ready); end
        tick();
        req0_valid = 1'b0;
        #1;
        vectors++; if (req1_ready !== 1'b1) begin miscompares++; $display("FAIL cont_ready1_next got %b want 1", req1_ready); end
        vectors++; if (RegWrite !== 1'b1 || rd !== 5'd3) begin miscompares++; $display("FAIL cont_write3 got we=%b rd=%0d want we=1 rd=3", RegWrite, rd); end
        tick();
        req1_valid = 1'b0;
        vectors++; if (RegWrite !== 1'b1 || rd !== 5'd4 || write_data !== 32'h0000_0444) begin miscompares++; $display("FAIL cont_write4 got we=%b rd=%0d wd=%h want we=1 rd=4 wd=00000444", RegWrite, rd, write_data); end
        tick();
        vectors++; if (RegWrite !== 1'b0) begin miscompares++; $display("FAIL cont_idle got %b want 0", RegWrite); end
    endtask

    task automatic test_starvation;
        req0_valid = 1'b1; req0_rd = 5'd2; req0_data = 32'h22;
        req1_valid = 1'b1; req1_rd = 5'd7; req1_data = 32'h77;
        for (int i = 1; i <= 4; i++) begin
            #1;
            vectors++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin miscompares++; $display("FAIL starve_stall%0d got r0=%b r1=%b want r0=1 r1=0", i, req0_ready, req1_ready); end
            tick();
        end
        #1;
        vectors++; if (req0_ready !== 1'b0 || req1_ready !== 1'b1) begin miscompares++; $display("FAIL starve_grant got r0=%b r1=%b want r0=0 r1=1", req0_ready, req1_ready); end
        tick();
        req1_rd = 5'd8; req1_data = 32'h88;
        #1;
        vectors++; if (RegWrite !== 1'b1 || rd !== 5'd7 || write_data !== 32'h77) begin miscompares++; $display("FAIL starve_write7 got we=%b rd=%0d wd=%h want we=1 rd=7 wd=00000077", RegWrite, rd, write_data); end
        vectors++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin miscompares++; $display("FAIL starve_prio_clear got r0=%b r1=%b want r0=1 r1=0", req0_ready, req1_ready); end
        tick();
        req0_valid = 1'b0;
        #1;
        vectors++; if (RegWrite !== 1'b1 || rd !== 5'd2 || write_data !== 32'h22) begin miscompares++; $display("FAIL starve_write2 got we=%b rd=%0d wd=%h want we=1 rd=2 wd=00000022", RegWrite, rd, write_data); end
        vectors++; if (req1_ready !== 1'b1) begin miscompares++; $display("FAIL starve_ready1_late got %b want 1", req1_ready); end
        tick();
        req1_valid = 1'b0;
        vectors++; if (RegWrite !== 1'b1 || rd !== 5'd8) begin miscompares++; $display("FAIL starve_write8 got we=%b rd=%0d want we=1 rd=8", RegWrite, rd); end
        tick();
    endtask

    task automatic test_hazard;
        req1_valid = 1'b1; req1_rd = 5'd9; req1_data = 32'h99; q_rs1 = 5'd9; q_rs2 = 5'd0;
        #1;
        vectors++; if (q_hit1 !== 1'b1) begin miscompares++; $display("FAIL haz_req1 got %b want 1", q_hit1); end
        vectors++; if (q_hit2 !== 1'b0) begin miscompares++; $display("FAIL haz_x0_a got %b want 0", q_hit2); end
        tick();
        req1_valid = 1'b0;
        #1;
        vectors++; if (q_hit1 !== 1'b1) begin miscompares++; $display("FAIL haz_outstage got %b want 1", q_hit1); end
        vectors++; if (q_hit2 !== 1'b0) begin miscompares++; $display("FAIL haz_x0_b got %b want 0", q_hit2); end
        tick();
        vectors++; if (q_hit1 !== 1'b0) begin miscompares++; $display("FAIL haz_cleared got %b want 0", q_hit1); end
        req0_valid = 1'b1; req0_rd = 5'd11; req0_data = 32'hB; q_rs1 = 5'd12; q_rs2 = 5'd11;
        #1;
        vectors++; if (q_hit2 !== 1'b1 || q_hit1 !== 1'b0) begin miscompares++; $display("FAIL haz_req0 got h1=%b h2=%b want h1=0 h2=1", q_hit1, q_hit2); end
        tick();
        req0_valid = 1'b0; q_rs2 = 5'd0;
        #1;
        vectors++; if (q_hit2 !== 1'b0) begin miscompares++; $display("FAIL haz_x0_c got %b want 0", q_hit2); end
        tick();
    endtask

    task automatic test_x0_drop;
        req1_valid = 1'b1; req1_rd = 5'd0; req1_data = 32'h1234;
        #1;
        vectors++; if (req1_ready !== 1'b1) begin miscompares++; $display("FAIL x0_ready1 got %b want 1", req1_ready); end
        tick();
        req1_valid = 1'b0;
        vectors++; if (RegWrite !== 1'b0 || rd !== 5'd11 || write_data !== 32'hB) begin miscompares++; $display("FAIL x0_nowrite got we=%b rd=%0d wd=%h want we=0 rd=11 wd=0000000b", RegWrite, rd, write_data); end
        req0_valid = 1'b1; req0_rd = 5'd0; req0_data = 32'h5;
        req1_valid = 1'b1; req1_rd = 5'd0; req1_data = 32'h6;
        #1;
        vectors++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin miscompares++; $display("FAIL x0_both got r0=%b r1=%b want r0=1 r1=0", req0_ready, req1_ready); end
        tick();
        req0_valid = 1'b0;
        #1;
        vectors++; if (req1_ready !== 1'b1 || RegWrite !== 1'b0) begin miscompares++; $display("FAIL x0_second got r1=%b we=%b want r1=1 we=0", req1_ready, RegWrite); end
        tick();
        req1_valid = 1'b0;
        vectors++; if (RegWrite !== 1'b0) begin miscompares++; $display("FAIL x0_second_nowrite got %b want 0", RegWrite); end
    endtask

    task automatic test_back_to_back;
        req0_valid = 1'b1; req0_rd = 5'd10; req0_data = 32'h1010;
        #1;
        vectors++; if (req0_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready_a got %b want 1", req0_ready); end
        tick();
        req0_rd = 5'd12; req0_data = 32'h1212;
        vectors++; if (RegWrite !== 1'b1 || rd !== 5'd10 || write_data !== 32'h1010) begin miscompares++; $display("FAIL b2b_first got we=%b rd=%0d wd=%h want we=1 rd=10 wd=00001010", RegWrite, rd, write_data); end
        tick();
        req0_valid = 1'b0;
        vectors++; if (RegWrite !== 1'b1 || rd !== 5'd12 || write_data !== 32'h1212) begin miscompares++; $display("FAIL b2b_second got we=%b rd=%0d wd=%h want we=1 rd=12 wd=00001212", RegWrite, rd, write_data); end
        tick();
        vectors++; if (RegWrite !== 1'b0) begin miscompares++; $display("FAIL b2b_idle got %b want 0", RegWrite); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_contention();
        test_starvation();
        test_hazard();
        test_x0_drop();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
